spi_transaction_arbiter: RTL and testbench

SPI_TRANSACTION_ARBITER -- requirements
Module: spi_transaction_arbiter

---
 rtl/spi_transaction_arbiter.sv | 150 +++++++++++++++
 tb/tb_spi_transaction_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_transaction_arbiter.sv
// Round-robin arbiter granting NUM_REQ requesters access to one SPI transaction port.
// Define SPI_ARB_TIMEOUT_EN to enable the WAIT-state watchdog.
module spi_transaction_arbiter #(
  parameter int NUM_REQ               = 4,
  parameter int DATA_WIDTH            = 32,
  parameter int TRANSACTION_LEN_WIDTH = 6,
  parameter int TIMEOUT_WIDTH         = 16
) (
  input  logic                                     fabric_clk,
  input  logic                                     reset_n,
  input  logic [NUM_REQ-1:0]                       req,
  input  logic [NUM_REQ*TRANSACTION_LEN_WIDTH-1:0] req_length,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]            req_data,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]            req_rw_mask,
  output logic [NUM_REQ-1:0]                       ack,
  output logic [DATA_WIDTH-1:0]                    rsp_data,
  output logic                                     rsp_err,
  output logic                                     busy,
  input  logic [TIMEOUT_WIDTH-1:0]                 timeout_cycles,
  output logic [TRANSACTION_LEN_WIDTH-1:0]         transaction_length,
  output logic [DATA_WIDTH-1:0]                    transaction_data,
  output logic [DATA_WIDTH-1:0]                    transaction_rw_mask,
  input  logic [DATA_WIDTH-1:0]                    transaction_read_data,
  input  logic                                     spi_done
);

  localparam int LW = TRANSACTION_LEN_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]    state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] grant;
  logic [PW-1:0] pick;
  logic          found;
  int            idx;
  logic          expired;

  logic [LW-1:0] len_arr  [NUM_REQ];
  logic [DW-1:0] data_arr [NUM_REQ];
  logic [DW-1:0] mask_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign len_arr[i]  = req_length[i*LW +: LW];
    assign data_arr[i] = req_data[i*DW +: DW];
    assign mask_arr[i] = req_rw_mask[i*DW +: DW];
  end

  // Scan downward so the nearest set bit at or after rr_ptr wins.
  always_comb begin
    pick  = rr_ptr;
    found = 1'b0;
    idx   = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[PW'(idx)]) begin
        pick  = PW'(idx);
        found = 1'b1;
      end
    end
  end

  logic [LW-1:0] pick_len;
  logic [LW-1:0] sat_len;

  assign pick_len = len_arr[pick];
  assign sat_len  = (32'(pick_len) > DW) ? LW'(DW) : pick_len;

`ifdef SPI_ARB_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] wd;

  assign expired = (timeout_cycles != '0) && (wd == timeout_cycles);

  always_ff @(posedge fabric_clk or negedge reset_n) begin
    if (!reset_n) begin
      wd <= '0;
    end else if (state == S_ISSUE) begin
      wd <= '0;
    end else if (state == S_WAIT) begin
      wd <= wd + 1'b1;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = ^timeout_cycles;
  assign expired        = 1'b0;
`endif

  always_ff @(posedge fabric_clk or negedge reset_n) begin
    if (!reset_n) begin
      state               <= S_IDLE;
      rr_ptr              <= '0;
      grant               <= '0;
      rsp_data            <= '0;
      rsp_err             <= 1'b0;
      transaction_length  <= '0;
      transaction_data    <= '0;
      transaction_rw_mask <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (found) begin
            grant <= pick;
            if (sat_len == '0) begin
              rsp_data <= '0;
              rsp_err  <= 1'b0;
              state    <= S_RESP;
            end else begin
              transaction_length  <= sat_len;
              transaction_data    <= data_arr[pick];
              transaction_rw_mask <= mask_arr[pick];
              state               <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          transaction_length <= '0;
          state              <= S_WAIT;
        end
        S_WAIT: begin
          if (spi_done) begin
            rsp_data <= transaction_read_data;
            rsp_err  <= 1'b0;
            state    <= S_RESP;
          end else if (expired) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
            state    <= S_RESP;
          end
        end
        S_RESP: begin
          rr_ptr <= (grant == PW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ack  = (state == S_RESP) ? (NUM_REQ'(1) << grant) : '0;
  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_spi_transaction_arbiter.sv
// Self-checking bench for spi_transaction_arbiter: directed scenarios
// plus randomized traffic against a timestamp-based transaction model.
module tb_spi_transaction_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int LW = 6;
  localparam int TW = 16;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*LW-1:0] req_length = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N*DW-1:0] req_rw_mask = '0;
  logic [N-1:0]    ack;
  logic [DW-1:0]   rsp_data;
  logic            rsp_err;
  logic            busy;
  logic [TW-1:0]   tmo = '0;
  logic [LW-1:0]   tl;
  logic [DW-1:0]   td;
  logic [DW-1:0]   tm;
  logic [DW-1:0]   rd = '0;
  logic            done = 1'b0;

  int checks = 0;
  int failures = 0;

  spi_transaction_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW),
    .TRANSACTION_LEN_WIDTH(LW), .TIMEOUT_WIDTH(TW)
  ) dut (
    .fabric_clk(clk), .reset_n(rst_n), .req(req),
    .req_length(req_length), .req_data(req_data),
    .req_rw_mask(req_rw_mask), .ack(ack), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy), .timeout_cycles(tmo),
    .transaction_length(tl), .transaction_data(td),
    .transaction_rw_mask(tm), .transaction_read_data(rd),
    .spi_done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Model: a transaction is a record of cycle stamps (issue, wait start, ack).
  int          cyc = 0;
  bit          m_active = 0;
  int          m_g = 0, m_ptr = 0, m_len = 0;
  int          m_issue = -10, m_wfrom = 0, m_ackc = -10;
  logic [DW-1:0] m_data = '0, m_mask = '0, m_rsp = '0;
  bit          m_err = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_ptr = 0; m_g = 0;
      m_issue = -10; m_ackc = -10;
      m_data = '0; m_mask = '0; m_rsp = '0; m_err = 0;
    end else begin
      if (!m_active) begin
        if (req != '0) begin
          m_g = -1;
          for (int k = 0; k < N; k++)
            if (m_g < 0 && req[(m_ptr + k) % N]) m_g = (m_ptr + k) % N;
          m_len = int'(req_length[m_g*LW +: LW]);
          if (m_len > DW) m_len = DW;
          m_active = 1;
          m_wfrom = cyc + 2;
          if (m_len == 0) begin
            m_issue = -10; m_ackc = cyc + 1; m_rsp = '0; m_err = 0;
          end else begin
            m_issue = cyc + 1; m_ackc = -1;
            m_data = req_data[m_g*DW +: DW];
            m_mask = req_rw_mask[m_g*DW +: DW];
          end
        end
      end else if (m_ackc == cyc) begin
        m_active = 0;
        m_ptr = (m_g + 1) % N;
      end else if (m_ackc < 0 && cyc >= m_wfrom) begin
        if (done) begin
          m_ackc = cyc + 1; m_rsp = rd; m_err = 0;
        end else if (TO_EN && tmo != '0 && cyc - m_wfrom == int'(tmo)) begin
          m_ackc = cyc + 1; m_rsp = '0; m_err = 1;
        end
      end
      cyc = cyc + 1;
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] ea;
    ea = '0;
    if (m_active && cyc == m_ackc) ea[m_g] = 1'b1;
    chk("ack", 64'(ack), 64'(ea));
    chk("busy", 64'(busy), 64'(m_active));
    chk("len", 64'(tl), (cyc == m_issue) ? 64'(m_len) : 64'd0);
    chk("data", 64'(td), 64'(m_data));
    chk("mask", 64'(tm), 64'(m_mask));
    if (ea != '0) begin
      chk("rsp_data", 64'(rsp_data), 64'(m_rsp));
      chk("rsp_err", 64'(rsp_err), 64'(m_err));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int i, input int len,
                      input logic [DW-1:0] d, input logic [DW-1:0] m);
    req_length[i*LW +: LW] = LW'(len);
    req_data[i*DW +: DW]   = d;
    req_rw_mask[i*DW +: DW] = m;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; done = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    int n;
    do_reset();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_len", 64'(tl), 64'd0);
    chk("rst_rsp", 64'(rsp_data), 64'd0);

    // single transaction, done after 40 cycles
    load(0, 16, 32'hA5A50000, 32'hFFFF0000);
    req = 4'b0001;
    step();
    chk("t1_len", 64'(tl), 64'd16);
    chk("t1_data", 64'(td), 64'hA5A50000);
    chk("t1_mask", 64'(tm), 64'hFFFF0000);
    for (int i = 2; i <= 40; i++) begin
      step();
      if (tl != '0) chk("t1_len_once", 64'(tl), 64'd0);
    end
    done = 1'b1; rd = 32'h0000BEEF;
    step();
    done = 1'b0;
    chk("t1_ack", 64'(ack), 64'b0001);
    chk("t1_rsp", 64'(rsp_data), 64'h0000BEEF);
    chk("t1_err", 64'(rsp_err), 64'd0);
    req = '0;
    step();
    chk("t1_ack_off", 64'(ack), 64'd0);

    // round robin with all requesters held
    do_reset();
    for (int i = 0; i < N; i++) load(i, 4, 32'h100 + 32'(i), 32'hF);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (tl == '0 && n < 6) begin step(); n++; end
      chk("rr_data", 64'(td), 64'(32'h100 + 32'(k % N)));
      step();
      done = 1'b1; rd = 32'(k);
      step();
      done = 1'b0;
      chk("rr_ack", 64'(ack), 64'(4'b0001 << (k % N)));
      step();
      chk("rr_idle", 64'(busy), 64'd0);
    end
    req = '0;
    step(); step();

    // watchdog
    tmo = 16'd10;
    load(0, 8, 32'h11, 32'h1);
    req = 4'b0001;
    n = 0;
    do begin step(); n++; end while (ack == '0 && n < 40);
    if (TO_EN) begin
      chk("to_cycles", 64'(n), 64'd13);
      chk("to_err", 64'(rsp_err), 64'd1);
      chk("to_rsp", 64'(rsp_data), 64'd0);
    end else begin
      chk("to_noack", 64'(ack), 64'd0);
      done = 1'b1; rd = 32'h1234;
      step();
      done = 1'b0;
      chk("to_ack", 64'(ack), 64'b0001);
      chk("to_err0", 64'(rsp_err), 64'd0);
    end
    req = '0; tmo = '0;
    step();

    // zero and oversized lengths
    load(1, 0, 32'h22, 32'h2);
    req = 4'b0010;
    step();
    chk("z_ack", 64'(ack), 64'b0010);
    chk("z_len", 64'(tl), 64'd0);
    chk("z_rsp", 64'(rsp_data), 64'd0);
    req = '0;
    step();
    load(2, 63, 32'h33, 32'h3);
    req = 4'b0100;
    step();
    chk("sat_len", 64'(tl), 64'd32);
    step();
    done = 1'b1; rd = 32'h5;
    step();
    done = 1'b0; req = '0;
    chk("sat_ack", 64'(ack), 64'b0100);
    step();

    // reset during WAIT
    load(0, 5, 32'h44, 32'h4);
    req = 4'b0001;
    step(); step(); step();
    rst_n = 1'b0; req = '0;
    step();
    chk("ab_ack", 64'(ack), 64'd0);
    chk("ab_busy", 64'(busy), 64'd0);
    step();
    load(1, 7, 32'hAAAA0001, 32'h1);
    load(3, 7, 32'hAAAA0003, 32'h3);
    rst_n = 1'b1; req = 4'b1010;
    step();
    chk("ab_grant", 64'(td), 64'hAAAA0001);
    step();
    done = 1'b1; rd = 32'h77;
    step();
    done = 1'b0;
    chk("ab_ack1", 64'(ack), 64'b0010);
    req = '0;
    step();

    // spi_done coincident with timeout, then spi_done in IDLE
    do_reset();
    tmo = 16'd5;
    load(0, 3, 32'h55, 32'h5);
    req = 4'b0001;
    for (int i = 0; i < 7; i++) step();
    done = 1'b1; rd = 32'hCAFE0001;
    step();
    done = 1'b0;
    chk("co_ack", 64'(ack), 64'b0001);
    chk("co_err", 64'(rsp_err), 64'd0);
    chk("co_rsp", 64'(rsp_data), 64'hCAFE0001);
    req = '0;
    step();
    done = 1'b1;
    step();
    done = 1'b0;
    chk("idle_done_ack", 64'(ack), 64'd0);
    chk("idle_done_busy", 64'(busy), 64'd0);
    tmo = '0;
    step();

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (ack[i]) begin
          req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 4) == 0) begin
          int len;
          case ($urandom_range(0, 5))
            0: len = 0;
            1: len = 63;
            2: len = 33;
            default: len = int'($urandom_range(1, 32));
          endcase
          load(i, len, $urandom, $urandom);
          req[i] = 1'b1;
        end else if (req[i] && $urandom_range(0, 60) == 0) begin
          req[i] = 1'b0;
        end
      end
      done = ($urandom_range(0, 6) == 0);
      rd = $urandom;
      if ($urandom_range(0, 200) == 0) tmo = TW'($urandom_range(0, 12));
      rst_n = ($urandom_range(0, 500) != 0);
    end
    rst_n = 1'b1; done = 1'b0; req = '0;
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
